// File: rtl/generic_sram_req_adapter_if.sv
// Byte-enable SRAM port bundle shared by the request adapter (master) and the SRAM wrapper (slave).
interface generic_sram_byte_en_if #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 32
);
  logic [ADDR_BITS-1:0]   addr;
  logic [DATA_BITS-1:0]   write_data;
  logic [DATA_BITS-1:0]   read_data;
  logic                   write_en;
  logic [DATA_BITS/8-1:0] byte_en;

  modport master (output addr, output write_data, output write_en, output byte_en,
                  input read_data);
  modport slave  (input addr, input write_data, input write_en, input byte_en,
                  output read_data);
endinterface

// File: rtl/generic_sram_req_adapter.sv
// Valid/ready request stream to byte-enable SRAM accesses, with an in-order response FIFO
// that absorbs the one-cycle read latency under consumer back-pressure.
module generic_sram_req_adapter #(
  parameter int unsigned MEM_ADDR_BITS = 10,
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned RSP_DEPTH     = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [MEM_ADDR_BITS-1:0]   req_addr,
  input  logic [MEM_DATA_BITS-1:0]   req_wdata,
  input  logic [MEM_DATA_BITS/8-1:0] req_byte_en,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MEM_DATA_BITS-1:0]   rsp_rdata,
  output logic                       rsp_write,
  generic_sram_byte_en_if.master     m
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RSP_DEPTH - 1);
  localparam logic [CntW:0]   DepthW  = (CntW + 1)'(RSP_DEPTH);

  logic [CntW-1:0]          fifo_count_q, fifo_count_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                     inflight_q, inflight_d;
  logic                     inflight_write_q, inflight_write_d;
  logic [MEM_DATA_BITS-1:0] fifo_data_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]     fifo_write_q;

  logic                     acc;
  logic                     push;
  logic                     pop;
  logic [CntW:0]            occupancy;
  logic [MEM_DATA_BITS-1:0] push_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses registered state only, so rsp_ready never reaches req_ready.
  always_comb begin
    occupancy = (CntW + 1)'(fifo_count_q) + (CntW + 1)'(inflight_q);
    req_ready = i_rstn & (occupancy < DepthW);
    acc       = req_valid & req_ready;
    push      = inflight_q;
    push_data = inflight_write_q ? '0 : m.read_data;

    m.addr       = req_addr;
    m.write_data = req_wdata;
    m.byte_en    = req_byte_en;
    m.write_en   = acc & req_write;

    rsp_valid = (fifo_count_q != '0);
    rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    rsp_write = rsp_valid & fifo_write_q[rd_ptr_q];
    pop       = rsp_valid & rsp_ready;
  end

  always_comb begin
    inflight_d       = acc;
    inflight_write_d = acc & req_write;
    wr_ptr_d         = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d         = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_count_d     = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + 1'b1;
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fifo_count_q     <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_write_q <= 1'b0;
    end else begin
      fifo_count_q     <= fifo_count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      inflight_q       <= inflight_d;
      inflight_write_q <= inflight_write_d;
    end
  end

  // Storage needs no reset: entries are only observed when fifo_count_q covers them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= push_data;
      fifo_write_q[wr_ptr_q] <= inflight_write_q;
    end
  end

endmodule

// File: tb/tb_generic_sram_req_adapter.sv
// Directed and randomised checks of generic_sram_req_adapter against a byte-lane memory model.
module tb_generic_sram_req_adapter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned Depth = 3;

  typedef struct {
    logic        w;
    logic [31:0] d;
    int unsigned cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_byte_en;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          preload;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned pop_cnt  = 0;
  logic        was_rst  = 1'b0;

  logic [31:0] sram_mem  [1024];
  logic [31:0] model_mem [1024];
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  generic_sram_byte_en_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) sram_if ();

  generic_sram_req_adapter #(
    .MEM_ADDR_BITS (AW),
    .MEM_DATA_BITS (DW),
    .RSP_DEPTH     (Depth)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_byte_en (req_byte_en),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_write   (rsp_write),
    .m           (sram_if)
  );

  function automatic logic [31:0] ramp(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= ramp(i);
    end else if (sram_if.write_en) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (sram_if.byte_en[b]) sram_mem[sram_if.addr][8*b +: 8] <= sram_if.write_data[8*b +: 8];
      end
    end
    sram_if.read_data <= sram_mem[sram_if.addr];
  end

  // Scoreboard: predicts credit, response timing and response contents every cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic        exp_valid;
    if (preload) begin
      for (int i = 0; i < 1024; i++) model_mem[i] = ramp(i);
    end
    if (was_rst) begin
      check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("post_rst_rsp_rdata", rsp_rdata, 32'd0);
      check_eq("post_rst_rsp_write", 32'(rsp_write), 32'd0);
    end
    if (!rstn) begin
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_write_en", 32'(sram_if.write_en), 32'd0);
      exp_q.delete();
    end else begin
      check_eq("mon_req_ready", 32'(req_ready), 32'(exp_q.size() < int'(Depth)));
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      check_eq("mon_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        check_eq("mon_rsp_rdata", rsp_rdata, exp_q[0].d);
        check_eq("mon_rsp_write", 32'(rsp_write), 32'(exp_q[0].w));
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (req_valid && req_ready) begin
        e.w   = req_write;
        e.d   = req_write ? 32'd0 : model_mem[req_addr];
        e.cyc = cyc;
        if (req_write) begin
          for (int b = 0; b < int'(BW); b++) begin
            if (req_byte_en[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
          end
        end
        exp_q.push_back(e);
      end
    end
    was_rst = !rstn;
  end

  initial begin
    int unsigned accepts;
    int unsigned pop_start;
    int unsigned n_acc;
    logic        acc_now;

    rstn        = 1'b0;
    preload     = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_byte_en = '0;
    rsp_ready   = 1'b0;
    repeat (2) tick();
    preload     = 1'b0;
    // A write presented during reset must not reach the SRAM.
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_byte_en = 4'hF;
    sample();
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_we", 32'(sram_if.write_en), 32'd0);
    tick();
    rstn      = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    sample();
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    // Reset mid-stream discards the in-flight read.
    tick();
    req_valid = 1'b1;
    req_addr  = 10'd3;
    tick();
    req_valid = 1'b0;
    rstn      = 1'b0;
    sample();
    check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
    tick();
    rstn = 1'b1;
    sample();
    check_eq("midrst_ready", 32'(req_ready), 32'd1);
    tick();
    sample();
    check_eq("midrst_no_stale", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 1'b1;
    req_addr  = 10'd9;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    sample();
    check_eq("midrst_first_valid", 32'(rsp_valid), 32'd1);
    check_eq("midrst_first_rdata", rsp_rdata, 32'h1000_0009);
    tick();
    sample();
    check_eq("midrst_single_rsp", 32'(rsp_valid), 32'd0);

    // Write then read of the same address in back-to-back cycles.
    tick();
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 10'd5;
    req_wdata   = 32'hDEAD_BEEF;
    req_byte_en = 4'hF;
    tick();
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    sample();
    check_eq("raw_wr_valid", 32'(rsp_valid), 32'd1);
    check_eq("raw_wr_flag", 32'(rsp_write), 32'd1);
    check_eq("raw_wr_rdata", rsp_rdata, 32'd0);
    tick();
    sample();
    check_eq("raw_rd_flag", 32'(rsp_write), 32'd0);
    check_eq("raw_rd_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Partial byte-enable merge.
    tick();
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 10'd7;
    req_wdata   = 32'h1122_3344;
    req_byte_en = 4'hF;
    tick();
    req_wdata   = 32'hAABB_CCDD;
    req_byte_en = 4'h5;
    tick();
    req_write = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    sample();
    check_eq("be_rd_flag", 32'(rsp_write), 32'd0);
    check_eq("be_rd_rdata", rsp_rdata, 32'h11BB_33DD);

    // Full throughput: one read per cycle, responses two cycles later.
    for (int i = 0; i < 64; i++) begin
      tick();
      req_valid = 1'b1;
      req_addr  = 10'(200 + i);
      sample();
      check_eq("tp_ready", 32'(req_ready), 32'd1);
      if (i >= 2) begin
        check_eq("tp_valid", 32'(rsp_valid), 32'd1);
        check_eq("tp_rdata", rsp_rdata, 32'h1000_0000 + 32'(200 + i - 2));
      end
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      req_valid = 1'b0;
      sample();
      check_eq("tp_tail_valid", 32'(rsp_valid), 32'd1);
      check_eq("tp_tail_rdata", rsp_rdata, 32'h1000_0000 + 32'(262 + j));
    end

    // Back-pressure: three credits, then one pop frees exactly one slot.
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 10'd300;
    accepts   = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      acc_now = req_ready;
      if (acc_now) accepts++;
      tick();
      if (acc_now) req_addr = req_addr + 1'b1;
    end
    check_eq("bp_accepts", accepts, 32'd3);
    sample();
    check_eq("bp_stalled", 32'(req_ready), 32'd0);
    pop_start = pop_cnt;
    tick();
    rsp_ready = 1'b1;
    sample();
    check_eq("bp_head_rdata", rsp_rdata, 32'h1000_012C);
    check_eq("bp_ready_during_pop", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    sample();
    check_eq("bp_ready_after_pop", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    sample();
    check_eq("bp_full_again", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b1;
    repeat (6) tick();
    sample();
    check_eq("bp_pops", pop_cnt - pop_start, 32'd4);
    check_eq("bp_drained", 32'(rsp_valid), 32'd0);

    // Randomised mixed traffic on a small address window to provoke hazards.
    n_acc     = 0;
    pop_start = pop_cnt;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      tick();
      req_valid   = 1'($urandom_range(0, 1));
      rsp_ready   = 1'($urandom_range(0, 1));
      req_write   = 1'($urandom_range(0, 1));
      req_addr    = 10'($urandom_range(0, 15));
      req_wdata   = $urandom;
      req_byte_en = 4'($urandom_range(0, 15));
      sample();
      if (req_valid && req_ready) n_acc++;
    end
    check_eq("rnd_accepts", n_acc, 32'd1000);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    sample();
    check_eq("rnd_pops", pop_cnt - pop_start, 32'd1000);
    check_eq("rnd_drained", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
